// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares the async FIFO's single write
// port among N_REQ valid/ready requesters, in the write-clock domain.
//
// Ports:
//   wr_clk_i      write-side clock (only clock)
//   wr_rst_ni     asynchronous active-low reset
//   req_valid_i   per-requester word valid
//   req_data_i    requester i data at [i*DW +: DW]
//   req_last_i    per-requester last word of packet (qualified by valid)
//   req_ready_o   per-requester accept, at most one bit high
//   full_i        FIFO full flag (wr_clk domain)
//   fifo_wr_en_o  FIFO write enable
//   fifo_data_o   FIFO write data
//   grant_id_o    index of the current grantee
//   busy_o        high while a grant is held
module fifo_wr_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned GW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                wr_clk_i,
  input  logic                wr_rst_ni,
  input  logic [N_REQ-1:0]    req_valid_i,
  input  logic [N_REQ*DW-1:0] req_data_i,
  input  logic [N_REQ-1:0]    req_last_i,
  output logic [N_REQ-1:0]    req_ready_o,
  input  logic                full_i,
  output logic                fifo_wr_en_o,
  output logic [DW-1:0]       fifo_data_o,
  output logic [GW-1:0]       grant_id_o,
  output logic                busy_o
);

  localparam int unsigned BCW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e         state_q, state_d;
  logic [GW-1:0]  grant_q, grant_d;
  logic [GW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [BCW-1:0] burst_cnt_q, burst_cnt_d;

  logic [DW-1:0]  data_arr [N_REQ];
  logic           arb_found;
  logic [GW-1:0]  arb_idx;
  logic [GW-1:0]  arb_cand;
  logic [GW-1:0]  next_ptr;
  logic           xfer;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      data_arr[i] = req_data_i[i*DW +: DW];
    end
  end

  // Scan from rr_ptr upward (wrapping) for the first valid requester.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_cand  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      arb_cand = GW'((32'(rr_ptr_q) + i) % N_REQ);
      if (!arb_found && req_valid_i[arb_cand]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand;
      end
    end
  end

  // The releasing grantee becomes the lowest priority at the next scan.
  assign next_ptr = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    burst_cnt_d  = burst_cnt_q;
    req_ready_o  = '0;
    fifo_wr_en_o = 1'b0;
    fifo_data_o  = '0;
    xfer         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_found) begin
          grant_d     = arb_idx;
          burst_cnt_d = '0;
          state_d     = StGrant;
        end
      end
      StGrant: begin
        req_ready_o[grant_q] = ~full_i;
        xfer                 = req_valid_i[grant_q] & ~full_i;
        fifo_wr_en_o         = xfer;
        fifo_data_o          = data_arr[grant_q];
        if (xfer) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
        // Dropping valid forfeits the grant even while the FIFO is full.
        if (!req_valid_i[grant_q] ||
            (xfer && (req_last_i[grant_q] || (burst_cnt_d == BCW'(MAX_BURST))))) begin
          state_d  = StIdle;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wr_clk_i or negedge wr_rst_ni) begin
    if (!wr_rst_ni) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign grant_id_o = grant_q;
  assign busy_o     = (state_q == StGrant);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          wr_clk;
  logic          wr_rst_n;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_last;
  logic [N-1:0]  req_ready;
  logic          full;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_data;
  logic [1:0]    grant_id;
  logic          busy;

  fifo_wr_arbiter #(
    .N_REQ    (N),
    .DW       (DW),
    .MAX_BURST(MB)
  ) dut (
    .wr_clk_i    (wr_clk),
    .wr_rst_ni   (wr_rst_n),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .full_i      (full),
    .fifo_wr_en_o(fifo_wr_en),
    .fifo_data_o (fifo_data),
    .grant_id_o  (grant_id),
    .busy_o      (busy)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the port, how many words it has written,
  // and who is next in round-robin order.
  int m_busy, m_gid, m_ptr, m_cnt;

  int wr_seen;
  int prev_busy;
  int grants[$];

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic        full;
    logic [31:0] data;
    logic        e_busy;
    logic [1:0]  e_gid;
    logic [3:0]  e_ready;
    logic        e_wr;
    logic [7:0]  e_data;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_gid = 0; m_ptr = 0; m_cnt = 0;
    prev_busy = 0;
  endtask

  task automatic model_step();
    int v, x;
    if (m_busy == 0) begin
      if (req_valid != 0) begin
        for (int k = 0; k < N; k++) begin
          if (req_valid[(m_ptr + k) % N]) begin
            m_gid = (m_ptr + k) % N;
            break;
          end
        end
        m_cnt  = 0;
        m_busy = 1;
      end
    end else begin
      v = int'(req_valid[m_gid]);
      x = (v != 0 && !full) ? 1 : 0;
      if (x != 0) m_cnt++;
      if (v == 0 || (x != 0 && (req_last[m_gid] || m_cnt == MB))) begin
        m_busy = 0;
        m_ptr  = (m_gid + 1) % N;
      end
    end
  endtask

  // One clock cycle: compare outputs against the model, then advance both.
  task automatic cycle();
    logic [3:0] e_ready;
    logic       e_wr;
    logic [7:0] e_data;
    #1;
    e_ready = '0;
    e_wr    = 1'b0;
    e_data  = '0;
    if (m_busy != 0) begin
      e_ready[m_gid] = ~full;
      e_wr           = req_valid[m_gid] & ~full;
      e_data         = req_data[m_gid*DW +: DW];
    end
    chk("busy",     32'(busy),       32'(m_busy));
    chk("grant_id", 32'(grant_id),   32'(m_gid));
    chk("ready",    32'(req_ready),  32'(e_ready));
    chk("wr_en",    32'(fifo_wr_en), 32'(e_wr));
    chk("data",     32'(fifo_data),  32'(e_data));
    if (fifo_wr_en) wr_seen++;
    if (busy && prev_busy == 0) grants.push_back(int'(grant_id));
    prev_busy = int'(busy);
    @(posedge wr_clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    wr_rst_n = 1'b0;
    @(posedge wr_clk);
    @(posedge wr_clk);
    #1;
    wr_rst_n = 1'b1;
    model_reset();
    wr_seen = 0;
    grants.delete();
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_last = '0; req_data = '0; full = 1'b0;
  endtask

  task automatic chk_grants(input string name, input int exp0, input int exp1,
                            input int exp2, input int exp3, input int exp4, input int n);
    int e [5];
    e[0] = exp0; e[1] = exp1; e[2] = exp2; e[3] = exp3; e[4] = exp4;
    chk({name, "_count"}, 32'(grants.size() >= n ? n : grants.size()), 32'(n));
    for (int k = 0; k < n && k < grants.size(); k++) begin
      chk(name, 32'(grants[k]), 32'(e[k]));
    end
  endtask

  initial begin
    tbl[0]  = '{4'b0010, 4'b0000, 1'b0, 32'h0000_A100, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};
    tbl[1]  = '{4'b0010, 4'b0000, 1'b0, 32'h0000_A100, 1'b1, 2'd1, 4'b0010, 1'b1, 8'hA1};
    tbl[2]  = '{4'b0010, 4'b0000, 1'b0, 32'h0000_A200, 1'b1, 2'd1, 4'b0010, 1'b1, 8'hA2};
    tbl[3]  = '{4'b0010, 4'b0010, 1'b0, 32'h0000_A300, 1'b1, 2'd1, 4'b0010, 1'b1, 8'hA3};
    tbl[4]  = '{4'b0000, 4'b0000, 1'b0, 32'h0000_0000, 1'b0, 2'd1, 4'b0000, 1'b0, 8'h00};
    tbl[5]  = '{4'b1111, 4'b0000, 1'b0, 32'h4433_2211, 1'b0, 2'd1, 4'b0000, 1'b0, 8'h00};
    tbl[6]  = '{4'b1111, 4'b0000, 1'b1, 32'h4433_2211, 1'b1, 2'd2, 4'b0000, 1'b0, 8'h33};
    tbl[7]  = '{4'b1111, 4'b0000, 1'b0, 32'h4433_2211, 1'b1, 2'd2, 4'b0100, 1'b1, 8'h33};
    tbl[8]  = '{4'b1011, 4'b0000, 1'b0, 32'h4433_2211, 1'b1, 2'd2, 4'b0100, 1'b0, 8'h33};
    tbl[9]  = '{4'b1011, 4'b0000, 1'b0, 32'h4433_2211, 1'b0, 2'd2, 4'b0000, 1'b0, 8'h00};
    tbl[10] = '{4'b1011, 4'b0000, 1'b0, 32'h4433_2211, 1'b1, 2'd3, 4'b1000, 1'b1, 8'h44};

    // Reset held with every requester valid: all outputs quiet.
    req_valid = 4'b1111; req_last = '0; req_data = 32'hDEAD_BEEF; full = 1'b0;
    wr_rst_n  = 1'b0;
    @(posedge wr_clk);
    @(posedge wr_clk);
    #1;
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_ready", 32'(req_ready),  32'd0);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_data",  32'(fifo_data),  32'd0);
    chk("rst_gid",   32'(grant_id),   32'd0);
    wr_rst_n = 1'b1;
    model_reset();
    cycle();
    chk("post_rst_busy", 32'(busy),     32'd1);
    chk("post_rst_gid",  32'(grant_id), 32'd0);

    // Table: single packet from requester 1, then round-robin from rr_ptr=2,
    // full hold, and a valid drop.
    idle_inputs();
    do_reset();
    for (int r = 0; r < 11; r++) begin
      req_valid = tbl[r].valid;
      req_last  = tbl[r].last;
      full      = tbl[r].full;
      req_data  = tbl[r].data;
      #1;
      chk($sformatf("tbl%0d_busy", r),  32'(busy),       32'(tbl[r].e_busy));
      chk($sformatf("tbl%0d_gid", r),   32'(grant_id),   32'(tbl[r].e_gid));
      chk($sformatf("tbl%0d_ready", r), 32'(req_ready),  32'(tbl[r].e_ready));
      chk($sformatf("tbl%0d_wr", r),    32'(fifo_wr_en), 32'(tbl[r].e_wr));
      chk($sformatf("tbl%0d_data", r),  32'(fifo_data),  32'(tbl[r].e_data));
      @(posedge wr_clk);
      #1;
    end

    // All four continuously valid, no last: 0,1,2,3,0 with 20 writes in 25 cycles.
    idle_inputs();
    do_reset();
    req_valid = 4'b1111;
    req_data  = 32'h3322_1100;
    for (int c = 0; c < 25; c++) cycle();
    chk("rr_writes", 32'(wr_seen), 32'd20);
    chk_grants("rr_order", 0, 1, 2, 3, 0, 5);

    // Full for 3 cycles after requester 0's 2nd word.
    idle_inputs();
    do_reset();
    req_valid = 4'b0001;
    req_data  = 32'h01; cycle();
    req_data  = 32'h01; cycle();
    req_data  = 32'h02; cycle();
    req_data  = 32'h03; full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("full_wr_en", 32'(fifo_wr_en),   32'd0);
      chk("full_ready", 32'(req_ready[0]), 32'd0);
      chk("full_busy",  32'(busy),         32'd1);
      cycle();
    end
    full = 1'b0;
    cycle();
    req_data = 32'h04; cycle();
    req_valid = 4'b0000;
    #1;
    chk("full_release", 32'(busy), 32'd0);
    cycle();
    chk("full_writes", 32'(wr_seen), 32'd4);

    // Requester 2 drops valid after one word; 3 then 1 follow.
    idle_inputs();
    do_reset();
    req_valid = 4'b0100;
    req_data  = 32'h7766_5544;
    cycle();
    cycle();
    req_valid = 4'b1010;
    for (int c = 0; c < 12; c++) cycle();
    chk_grants("drop_order", 2, 3, 1, 0, 0, 3);

    // Asynchronous reset during requester 3's 2nd word.
    idle_inputs();
    do_reset();
    req_valid = 4'b1000;
    req_data  = 32'hD100_0000;
    cycle();
    cycle();
    req_data = 32'hD200_0000;
    #1;
    chk("arst_pre_wr", 32'(fifo_wr_en), 32'd1);
    wr_rst_n = 1'b0;
    #1;
    chk("arst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("arst_ready", 32'(req_ready),  32'd0);
    chk("arst_busy",  32'(busy),       32'd0);
    chk("arst_data",  32'(fifo_data),  32'd0);
    @(posedge wr_clk);
    #1;
    wr_rst_n = 1'b1;
    model_reset();
    grants.delete();
    req_valid = 4'b1111;
    cycle();
    cycle();
    chk_grants("arst_restart", 0, 0, 0, 0, 0, 1);

    // Randomized traffic against the model.
    idle_inputs();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_last  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      req_data  = $urandom;
      full      = ($urandom_range(0, 9) < 3);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
